multicycle_state_sequencer: RTL and testbench
=============================================

// Module: multicycle_state_sequencer
// PURPOSE
//  Control-step FSM of the multi-cycle MIPS CPU; sits directly upstream of the control-signal LUT.
//  Produces the 3-bit step code (IF/ID/EXEC/MEM/WB) that the LUT combines with the instruction to drive datapath enables.
//  Sequences each instruction class through its required steps and stalls IF/memory steps on a memory-ready handshake.
//  Keeps retired-instruction and cycle counters and flags undecodable instructions.
// PARAMETERS
//  COUNT_WIDTH   32  width of instr_count and cycle_count
//  USE_MEM_READY 1   1: IF and LW/SW MEM wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  reset        in   1   synchronous, active-high
//  opcode       in   6   instruction[31:26] from IR; stable from ID onward
//  funct        in   6   instruction[5:0] from IR
//  mem_ready    in   1   memory has completed current fetch/load/store
//  state        out  3   current step: IF=0, ID=1, EXEC=2, MEM=3, WB=4
//  instr_done   out  1   high during final step of a legal instruction, when that step advances
//  illegal_op   out  1   one-cycle pulse in ID when opcode/funct undecodable
//  instr_count  out  CW  legal instructions retired
//  cycle_count  out  CW  clocks since reset
// BEHAVIOUR
//  Reset (sync, high): state=IF, instr_done=0, illegal_op=0, counters=0, latched class=NONE. First post-reset cycle is IF.
//  Class decode (combinational on opcode/funct) during ID only; registered on ID exit; later steps use the latched class only.
//  Step paths (every arrow is one clock unless stalled):
//   LW (100011), BEQ (000100), BNE (000101): IF>ID>EXEC>MEM>WB>IF
//   SW (101011), JAL (000011):               IF>ID>EXEC>MEM>IF
//   RTYPE add/sub/slt (100000/100010/101010), ADDI (001000), XORI (001110): IF>ID>EXEC>WB>IF
//   RTYPE jr (funct 001000):                 IF>ID>EXEC>IF
//   J (000010):                              IF>ID>IF
//   Other opcode, or RTYPE with other funct: IF>ID>IF, illegal_op=1 for that ID cycle, not counted.
//  Stalls: in IF, stay in IF while mem_ready=0; in MEM, stay while mem_ready=0 only for LW/SW (JAL/BEQ/BNE MEM never stall).
//  instr_done: combinational = (final step of path) & (step advances this cycle); never for illegal or stalled step.
//  instr_count += 1 on each clock where instr_done=1; cycle_count += 1 every non-reset clock.
//  Counters are unsigned COUNT_WIDTH, wrap modulo 2^CW silently.
//  Illegal state encodings 5..7 (e.g. upset): next state IF, illegal_op=1 that cycle, class cleared.
//  Reset mid-instruction: abandon instruction, no instr_done, counters to 0, next cycle IF.
//  Simultaneous reset and any stall/done: reset wins.
//  opcode changes after ID: no effect on current path.
// STRUCTURE
//  Shared include cpu_defines.vh: step codes IF/ID/EXEC/MEM/WB, opcode and funct constants, class codes
//   (CL_NONE, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_ALU, CL_JR, CL_J, CL_ILLEGAL) - same file the control LUT includes.
//  Sub-module: multicycle_op_classify (pure combinational opcode/funct -> class); FSM, stall logic and counters in this module.
// TESTING
//  LW, mem_ready=1 -> state 0,1,2,3,4,0; instr_done only in WB cycle; instr_count=1 after 5 clocks.
//  J then ADD (000000/100000) -> states 0,1,0,1,2,4,0; instr_done in ID of J and WB of ADD; instr_count=2.
//  JR vs ADDI same opcode slot in funct -> JR path 0,1,2,0, ADDI path 0,1,2,4,0.
//  SW with mem_ready=0 for 3 cycles in IF and 2 in MEM -> IF held 4 cycles, MEM held 3; cycle_count=+5 over ideal; one instr_done.
//  BEQ with mem_ready=0 in MEM -> no stall, 5-step path unchanged.
//  Opcode 111111 -> illegal_op pulse in ID, back to IF, instr_count unchanged.
//  Reset asserted in EXEC of LW -> next state IF, counters 0, no instr_done.
//  COUNT_WIDTH=4, 16 J instructions -> instr_count wraps to 0; cycle_count wraps without glitch.
//  USE_MEM_READY=0, mem_ready held 0 -> LW completes in 5 clocks.

Source files
------------

// File: rtl/multicycle_state_sequencer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_state_sequencer_pkg : step codes, opcode/funct constants, classes
// Revision: 1.0
// ---------------------------------------------------------------------------
package multicycle_state_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4
    } step_t;

    typedef enum logic [3:0] {
        CL_NONE    = 4'd0,
        CL_LOAD    = 4'd1,
        CL_STORE   = 4'd2,
        CL_BRANCH  = 4'd3,
        CL_JAL     = 4'd4,
        CL_ALU     = 4'd5,
        CL_JR      = 4'd6,
        CL_J       = 4'd7,
        CL_ILLEGAL = 4'd8
    } op_class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Only data-memory accesses wait on the memory handshake in MEM.
    function automatic logic is_mem_access(input op_class_t cls);
        return (cls == CL_LOAD) || (cls == CL_STORE);
    endfunction

    // Classes whose path ends in MEM rather than continuing to WB.
    function automatic logic ends_in_mem(input op_class_t cls);
        return (cls == CL_STORE) || (cls == CL_JAL);
    endfunction

endpackage : multicycle_state_sequencer_pkg
`default_nettype wire

// File: rtl/multicycle_state_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_state_sequencer_if : instruction/handshake inputs and step outputs
// Revision: 1.0
// ---------------------------------------------------------------------------
interface multicycle_state_sequencer_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [5:0]             opcode;
    logic [5:0]             funct;
    logic                   mem_ready;
    logic [2:0]             state;
    logic                   instr_done;
    logic                   illegal_op;
    logic [COUNT_WIDTH-1:0] instr_count;
    logic [COUNT_WIDTH-1:0] cycle_count;

    modport master (
        output opcode, funct, mem_ready,
        input  state, instr_done, illegal_op, instr_count, cycle_count
    );

    modport slave (
        input  opcode, funct, mem_ready,
        output state, instr_done, illegal_op, instr_count, cycle_count
    );
endinterface : multicycle_state_sequencer_if
`default_nettype wire

// File: rtl/multicycle_state_sequencer_op_classify.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_op_classify : combinational opcode/funct -> instruction class
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_op_classify
    import multicycle_state_sequencer_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CL_ILLEGAL;
        case (opcode)
            OP_LW:            op_class = CL_LOAD;
            OP_SW:            op_class = CL_STORE;
            OP_BEQ, OP_BNE:   op_class = CL_BRANCH;
            OP_JAL:           op_class = CL_JAL;
            OP_ADDI, OP_XORI: op_class = CL_ALU;
            OP_J:             op_class = CL_J;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_SLT: op_class = CL_ALU;
                    FN_JR:                  op_class = CL_JR;
                    default:                op_class = CL_ILLEGAL;
                endcase
            end
            default:          op_class = CL_ILLEGAL;
        endcase
    end

endmodule : multicycle_op_classify
`default_nettype wire

// File: rtl/multicycle_state_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multicycle_state_sequencer : multi-cycle MIPS control-step FSM with counters
// Revision: 1.0
// ---------------------------------------------------------------------------
module multicycle_state_sequencer
    import multicycle_state_sequencer_pkg::*;
#(
    parameter int COUNT_WIDTH   = 32,
    parameter int USE_MEM_READY = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    multicycle_state_sequencer_if.slave   bus
);

    step_t                  r_state;
    step_t                  w_state_next;
    op_class_t              r_class;
    op_class_t              w_class_next;
    op_class_t              w_decoded;
    logic                   w_ready;
    logic                   w_done;
    logic                   w_illegal;
    logic [COUNT_WIDTH-1:0] r_instr_count;
    logic [COUNT_WIDTH-1:0] r_cycle_count;

    multicycle_op_classify u_classify (
        .opcode   (bus.opcode),
        .funct    (bus.funct),
        .op_class (w_decoded)
    );

    // With the handshake disabled memory is always considered ready.
    assign w_ready = bus.mem_ready | (USE_MEM_READY == 0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IF;
            r_class <= CL_NONE;
        end else begin
            r_state <= w_state_next;
            r_class <= w_class_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_class_next = r_class;
        w_done       = 1'b0;
        w_illegal    = 1'b0;
        case (r_state)
            ST_IF: begin
                if (w_ready) begin
                    w_state_next = ST_ID;
                end
            end
            ST_ID: begin
                w_class_next = w_decoded;
                case (w_decoded)
                    CL_ILLEGAL: begin
                        w_illegal    = 1'b1;
                        w_state_next = ST_IF;
                    end
                    CL_J: begin
                        w_done       = 1'b1;
                        w_state_next = ST_IF;
                    end
                    default: w_state_next = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                case (r_class)
                    CL_JR: begin
                        w_done       = 1'b1;
                        w_state_next = ST_IF;
                    end
                    CL_ALU:                               w_state_next = ST_WB;
                    CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL: w_state_next = ST_MEM;
                    default:                              w_state_next = ST_IF;
                endcase
            end
            ST_MEM: begin
                if (is_mem_access(r_class) && !w_ready) begin
                    w_state_next = ST_MEM;
                end else if (ends_in_mem(r_class)) begin
                    w_done       = 1'b1;
                    w_state_next = ST_IF;
                end else if (r_class == CL_LOAD || r_class == CL_BRANCH) begin
                    w_state_next = ST_WB;
                end else begin
                    w_state_next = ST_IF;
                end
            end
            ST_WB: begin
                w_done       = 1'b1;
                w_state_next = ST_IF;
            end
            default: begin
                // Unreachable encoding (e.g. an upset): flag it and restart cleanly.
                w_illegal    = 1'b1;
                w_class_next = CL_NONE;
                w_state_next = ST_IF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr_count <= '0;
            r_cycle_count <= '0;
        end else begin
            r_cycle_count <= r_cycle_count + 1'b1;
            if (w_done) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
        end
    end

    assign bus.state       = r_state;
    assign bus.instr_done  = w_done & ~reset;
    assign bus.illegal_op  = w_illegal & ~reset;
    assign bus.instr_count = r_instr_count;
    assign bus.cycle_count = r_cycle_count;

endmodule : multicycle_state_sequencer
`default_nettype wire

// File: tb/tb_multicycle_state_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multicycle_state_sequencer : randomized bench with path-list reference model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_multicycle_state_sequencer;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100, BNE = 6'b000101;
    localparam logic [5:0] JAL = 6'b000011, ADDI = 6'b001000, XORI = 6'b001110, J = 6'b000010;
    localparam logic [5:0] RT = 6'b000000, BAD = 6'b111111;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_SLT = 6'b101010, F_JR = 6'b001000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   rand_phase = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    multicycle_state_sequencer_if #(.COUNT_WIDTH(32)) bus_a ();
    multicycle_state_sequencer_if #(.COUNT_WIDTH(4))  bus_b ();

    multicycle_state_sequencer #(.COUNT_WIDTH(32), .USE_MEM_READY(1)) dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_a.slave)
    );

    multicycle_state_sequencer #(.COUNT_WIDTH(4), .USE_MEM_READY(0)) dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (bus_b.slave)
    );

    // Reference model: each instruction is a list of steps following ID.
    int          m_st[2];
    int          m_idx[2];
    int          m_plen[2];
    int          m_path[2][3];
    bit          m_mw[2];
    logic [31:0] m_ic[2];
    logic [31:0] m_cc[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic decode(input logic [5:0] op, input logic [5:0] fn, output bit ill,
                          output int pl, output int p0, output int p1, output int p2, output bit mw);
        ill = 0; pl = 0; p0 = 0; p1 = 0; p2 = 0; mw = 0;
        if (op == LW) begin pl = 3; p0 = 2; p1 = 3; p2 = 4; mw = 1; end
        else if (op == BEQ || op == BNE) begin pl = 3; p0 = 2; p1 = 3; p2 = 4; end
        else if (op == SW) begin pl = 2; p0 = 2; p1 = 3; mw = 1; end
        else if (op == JAL) begin pl = 2; p0 = 2; p1 = 3; end
        else if (op == ADDI || op == XORI) begin pl = 2; p0 = 2; p1 = 4; end
        else if (op == J) pl = 0;
        else if (op == RT && (fn == F_ADD || fn == F_SUB || fn == F_SLT)) begin pl = 2; p0 = 2; p1 = 4; end
        else if (op == RT && fn == F_JR) begin pl = 1; p0 = 2; end
        else ill = 1;
    endtask

    task automatic mstep(input int k, input bit r, input logic [5:0] op, input logic [5:0] fn,
                         input bit mr, input bit use_mr, output bit done, output bit ill);
        int pl, p0, p1, p2;
        bit mw;
        done = 0;
        ill  = 0;
        if (r) begin
            m_st[k] = 0; m_idx[k] = 0; m_plen[k] = 0; m_mw[k] = 0; m_ic[k] = 0; m_cc[k] = 0;
            return;
        end
        m_cc[k] = m_cc[k] + 1;
        if (m_st[k] == 0) begin
            if (mr || !use_mr) m_st[k] = 1;
        end else if (m_st[k] == 1) begin
            decode(op, fn, ill, pl, p0, p1, p2, mw);
            if (ill) m_st[k] = 0;
            else if (pl == 0) begin done = 1; m_st[k] = 0; end
            else begin
                m_path[k][0] = p0; m_path[k][1] = p1; m_path[k][2] = p2;
                m_plen[k] = pl; m_mw[k] = mw; m_idx[k] = 0; m_st[k] = p0;
            end
        end else begin
            if (!(m_st[k] == 3 && m_mw[k] && use_mr && !mr)) begin
                if (m_idx[k] == m_plen[k] - 1) begin done = 1; m_st[k] = 0; end
                else begin m_idx[k] = m_idx[k] + 1; m_st[k] = m_path[k][m_idx[k]]; end
            end
        end
        if (done) m_ic[k] = m_ic[k] + 1;
    endtask

    task automatic compare_one(input int k, input string tag, input logic [2:0] st, input logic d,
                               input logic il, input logic [31:0] ic, input logic [31:0] cc,
                               input logic [5:0] op, input logic [5:0] fn, input bit mr,
                               input bit use_mr, input logic [31:0] mask, input bit en);
        int          st0;
        logic [31:0] ic0, cc0;
        bit          ed, eil;
        st0 = m_st[k]; ic0 = m_ic[k]; cc0 = m_cc[k];
        mstep(k, rst, op, fn, mr, use_mr, ed, eil);
        if (en) begin
            chk({tag, "_state"}, {29'd0, st}, st0);
            chk({tag, "_instr_done"}, {31'd0, d}, {31'd0, ed});
            chk({tag, "_illegal_op"}, {31'd0, il}, {31'd0, eil});
            chk({tag, "_instr_count"}, ic, ic0 & mask);
            chk({tag, "_cycle_count"}, cc, cc0 & mask);
        end
    endtask

    // Compare process: outputs are sampled mid-cycle while inputs are stable.
    initial begin
        bit en;
        en = 0;
        forever begin
            @(negedge clk);
            compare_one(0, "a", bus_a.state, bus_a.instr_done, bus_a.illegal_op,
                        bus_a.instr_count, bus_a.cycle_count,
                        bus_a.opcode, bus_a.funct, bus_a.mem_ready, 1'b1, 32'hFFFF_FFFF, en);
            compare_one(1, "b", bus_b.state, bus_b.instr_done, bus_b.illegal_op,
                        {28'd0, bus_b.instr_count}, {28'd0, bus_b.cycle_count},
                        bus_b.opcode, bus_b.funct, bus_b.mem_ready, 1'b0, 32'h0000_000F, en);
            if (rst) en = 1;
        end
    end

    task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input bit mr, input bit r);
        @(posedge clk);
        #1;
        rst             = r;
        bus_a.opcode    = op;
        bus_a.funct     = fn;
        bus_a.mem_ready = mr;
        bus_b.opcode    = op;
        bus_b.funct     = fn;
        bus_b.mem_ready = rand_phase ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
    endtask

    // One cycle on instance A with hand-computed literal expectations.
    task automatic lit(input logic [5:0] op, input logic [5:0] fn, input bit mr, input bit r,
                       input int est, input bit ed, input bit eil);
        cyc(op, fn, mr, r);
        chk("lit_state", {29'd0, bus_a.state}, est);
        chk("lit_done", {31'd0, bus_a.instr_done}, {31'd0, ed});
        chk("lit_illegal", {31'd0, bus_a.illegal_op}, {31'd0, eil});
    endtask

    logic [5:0]  ops[12] = '{LW, SW, BEQ, BNE, JAL, ADDI, XORI, J, RT, RT, BAD, 6'b010001};
    logic [5:0]  fns[5]  = '{F_ADD, F_SUB, F_SLT, F_JR, 6'b000111};
    logic [31:0] snap;

    initial begin
        bus_a.opcode = 0; bus_a.funct = 0; bus_a.mem_ready = 1;
        bus_b.opcode = 0; bus_b.funct = 0; bus_b.mem_ready = 0;

        cyc(J, 0, 1, 1);
        // LW: 0,1,2,3,4 then IF
        lit(LW, 0, 1, 0, 0, 0, 0);
        chk("reset_instr_count", bus_a.instr_count, 0);
        chk("reset_cycle_count", bus_a.cycle_count, 0);
        lit(LW, 0, 1, 0, 1, 0, 0);
        lit(LW, 0, 1, 0, 2, 0, 0);
        lit(LW, 0, 1, 0, 3, 0, 0);
        lit(LW, 0, 1, 0, 4, 1, 0);
        // J then ADD
        lit(J, 0, 1, 0, 0, 0, 0);
        chk("lw_instr_count", bus_a.instr_count, 1);
        chk("lw_cycle_count", bus_a.cycle_count, 5);
        lit(J, 0, 1, 0, 1, 1, 0);
        lit(RT, F_ADD, 1, 0, 0, 0, 0);
        lit(RT, F_ADD, 1, 0, 1, 0, 0);
        lit(RT, F_ADD, 1, 0, 2, 0, 0);
        lit(RT, F_ADD, 1, 0, 4, 1, 0);
        // JR then ADDI share the 001000 code in different fields
        lit(RT, F_JR, 1, 0, 0, 0, 0);
        chk("j_add_instr_count", bus_a.instr_count, 3);
        lit(RT, F_JR, 1, 0, 1, 0, 0);
        lit(RT, F_JR, 1, 0, 2, 1, 0);
        lit(ADDI, 0, 1, 0, 0, 0, 0);
        lit(ADDI, 0, 1, 0, 1, 0, 0);
        lit(ADDI, 0, 1, 0, 2, 0, 0);
        lit(ADDI, 0, 1, 0, 4, 1, 0);
        // SW with IF and MEM stalls
        lit(SW, 0, 0, 0, 0, 0, 0);
        snap = bus_a.cycle_count;
        lit(SW, 0, 0, 0, 0, 0, 0);
        lit(SW, 0, 0, 0, 0, 0, 0);
        lit(SW, 0, 1, 0, 0, 0, 0);
        lit(SW, 0, 1, 0, 1, 0, 0);
        lit(SW, 0, 1, 0, 2, 0, 0);
        lit(SW, 0, 0, 0, 3, 0, 0);
        lit(SW, 0, 0, 0, 3, 0, 0);
        lit(SW, 0, 1, 0, 3, 1, 0);
        // BEQ ignores mem_ready in MEM
        lit(BEQ, 0, 1, 0, 0, 0, 0);
        chk("sw_stall_cycles", bus_a.cycle_count - snap, 9);
        lit(BEQ, 0, 0, 0, 1, 0, 0);
        lit(BEQ, 0, 0, 0, 2, 0, 0);
        lit(BEQ, 0, 0, 0, 3, 0, 0);
        lit(BEQ, 0, 0, 0, 4, 1, 0);
        // Undecodable opcode
        lit(BAD, 0, 1, 0, 0, 0, 0);
        snap = bus_a.instr_count;
        lit(BAD, 0, 1, 0, 1, 0, 1);
        lit(LW, 0, 1, 0, 0, 0, 0);
        chk("illegal_not_counted", bus_a.instr_count, snap);
        // Reset in EXEC of LW
        lit(LW, 0, 1, 0, 1, 0, 0);
        lit(LW, 0, 1, 1, 2, 0, 0);
        lit(J, 0, 1, 0, 0, 0, 0);
        chk("mid_reset_instr_count", bus_a.instr_count, 0);
        chk("mid_reset_cycle_count", bus_a.cycle_count, 0);
        lit(J, 0, 1, 0, 1, 1, 0);
        // 16 J instructions: B's 4-bit counters wrap to zero
        for (int i = 0; i < 15; i++) begin
            lit(J, 0, 1, 0, 0, 0, 0);
            lit(J, 0, 1, 0, 1, 1, 0);
        end
        lit(LW, 0, 0, 0, 0, 0, 0);
        chk("wrap_a_instr_count", bus_a.instr_count, 16);
        chk("wrap_a_cycle_count", bus_a.cycle_count, 32);
        chk("wrap_b_instr_count", {28'd0, bus_b.instr_count}, 0);
        chk("wrap_b_cycle_count", {28'd0, bus_b.cycle_count}, 0);
        // B ignores mem_ready=0 while A stalls in IF
        chk("b_lw_state", {29'd0, bus_b.state}, 0);
        for (int s = 1; s <= 4; s++) begin
            cyc(LW, 0, 0, 0);
            chk("b_lw_state", {29'd0, bus_b.state}, s);
            chk("b_lw_done", {31'd0, bus_b.instr_done}, (s == 4) ? 1 : 0);
            chk("a_held_if", {29'd0, bus_a.state}, 0);
        end
        cyc(LW, 0, 0, 0);
        chk("b_lw_back_if", {29'd0, bus_b.state}, 0);

        // Randomized phase; opcode/funct change every cycle, including after ID.
        rand_phase = 1'b1;
        for (int n = 0; n < 4000; n++) begin
            cyc(ops[$urandom_range(0, 11)], fns[$urandom_range(0, 4)],
                ($urandom_range(0, 9) < 7), ($urandom_range(0, 149) == 0));
        end
        cyc(J, 0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multicycle_state_sequencer
`default_nettype wire
